// File: rtl/osecpu_pkg.sv
// osecpu_pkg: state encodings and opcode constants shared by the OSECPU sequencer and datapath.
package osecpu_pkg;
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_EXEC  = 4'd1,
    ST_FETCH = 4'd2,
    ST_PAUSE = 4'd3,
    ST_HALT  = 4'd4,
    ST_ERR   = 4'd5
  } state_e;
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LIMM16 = 8'h02;
  localparam logic [7:0] OP_CP     = 8'hd2;
  localparam logic [7:0] OP_ADD    = 8'h14;
  localparam logic [7:0] OP_SUB    = 8'h15;
  localparam logic [7:0] OP_CPDR   = 8'hd3;
  localparam logic [7:0] OP_HALT   = 8'hff;
endpackage

// File: rtl/osecpu_op_decode.sv
// osecpu_op_decode: classifies an opcode byte as executable, halt, or CPDR.
module osecpu_op_decode
  import osecpu_pkg::*;
(
  input  logic [7:0] i_op,
  output logic       o_legal,
  output logic       o_is_halt,
  output logic       o_is_cpdr
);
  always_comb begin
    o_legal   = i_op inside {OP_NOP, OP_LIMM16, OP_CP, OP_ADD, OP_SUB, OP_CPDR};
    o_is_halt = i_op == OP_HALT;
    o_is_cpdr = i_op == OP_CPDR;
  end
endmodule

// File: rtl/osecpu_seq_ctrl.sv
// osecpu_seq_ctrl: fetch/exec sequencer with run/step/halt control, fetch timeout and CPDR debug capture.
module osecpu_seq_ctrl
  import osecpu_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_step_mode,
  input  logic            i_step,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_data,
  input  logic [31:0]     i_ireg_d0,
  output logic [31:0]     o_instr0,
  output logic [3:0]      o_current_state,
  output logic [PC_W-1:0] o_pc,
  output logic [31:0]     o_dr,
  output logic            o_dr_valid,
  output logic            o_halted,
  output logic            o_error
);
  localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_PC);
  localparam logic [7:0]      TO_LAST = 8'(ACK_TIMEOUT - 1);
  state_e            r_state, w_next;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_instr0, r_dr;
  logic              r_dr_valid;
  logic [7:0]        r_cnt;
  logic              w_legal, w_is_halt, w_is_cpdr;
  logic              w_acc, w_start_ok, w_timeout, w_exec_cpdr;
  osecpu_op_decode u_dec (
    .i_op      (i_imem_data[31:24]),
    .o_legal   (w_legal),
    .o_is_halt (w_is_halt),
    .o_is_cpdr (w_is_cpdr)
  );
  assign w_acc       = r_state == ST_FETCH && i_imem_ack;
  assign w_start_ok  = i_start && r_state inside {ST_IDLE, ST_HALT, ST_ERR};
  assign w_timeout   = r_state == ST_FETCH && !i_imem_ack && r_cnt == TO_LAST;
  assign w_exec_cpdr = r_state == ST_EXEC && r_instr0[31:24] == OP_CPDR;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_HALT, ST_ERR: w_next = i_start ? ST_FETCH : r_state;
      ST_FETCH: w_next = w_acc ? (w_is_halt ? ST_HALT : w_legal ? ST_EXEC : ST_ERR)
                               : w_timeout ? ST_ERR : ST_FETCH;
      ST_EXEC:  w_next = i_step_mode ? ST_PAUSE : ST_FETCH;
      ST_PAUSE: w_next = i_step ? ST_FETCH : ST_PAUSE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_comb begin
    o_imem_req      = r_state == ST_FETCH;
    o_halted        = r_state == ST_HALT;
    o_error         = r_state == ST_ERR;
    o_current_state = r_state;
  end
  // counter only runs while a request is outstanding; any other cycle restarts it
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_pc       <= RST_PC;
      r_instr0   <= '0;
      r_dr       <= '0;
      r_dr_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pc       <= w_start_ok ? RST_PC : w_acc ? r_pc + PC_W'(1) : r_pc;
      r_instr0   <= w_acc ? i_imem_data : r_instr0;
      r_dr       <= w_exec_cpdr ? i_ireg_d0 : r_dr;
      r_dr_valid <= w_exec_cpdr;
      r_cnt      <= (r_state == ST_FETCH && !i_imem_ack) ? r_cnt + 8'd1 : '0;
    end
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_instr0    = r_instr0;
  assign o_dr        = r_dr;
  assign o_dr_valid  = r_dr_valid;
endmodule

// File: tb/tb_osecpu_seq_ctrl.sv
// tb_osecpu_seq_ctrl: scenario tasks plus randomized programs checked against an instruction-level interpreter.
module tb_osecpu_seq_ctrl;
  localparam int TO = 255;
  logic clk = 0, reset = 1, start = 0, step_mode = 0, step = 0;
  logic req, ack, drv, halted, error;
  logic [9:0] addr, pc;
  logic [31:0] idata, d0, instr0, dr;
  logic [3:0] cs;
  logic [31:0] mem [0:1023];
  logic [31:0] regs [0:7];
  logic ack_en = 1, rand_mode = 0, dp_clr = 0;
  int delay = 0, rnd = 0, wcnt = 0, eff_delay;
  logic rst2 = 1, start2 = 0, req2, drv2, halted2, error2;
  logic [1:0] addr2, pc2;
  logic [31:0] instr2, dr2;
  logic [3:0] cs2;
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] ex_w[$], dr_w[$], xw[$], xdr[$];
  int ex_c[$], dr_c[$], cp_c[$], runs[$];
  int run_len, bad_addr, bad_instr;
  logic [9:0] run_addr, xpc;
  logic [3:0] xstate;
  logic prev_acc;
  logic [31:0] prev_instr;

  always #5 clk = ~clk;
  assign eff_delay = rand_mode ? rnd : delay;
  assign ack   = req && ack_en && (wcnt >= eff_delay);
  assign idata = mem[addr];
  assign d0    = regs[instr0[18:16]];

  always @(posedge clk) begin
    wcnt <= (req && !ack) ? wcnt + 1 : 0;
    if (req && ack) rnd <= $urandom_range(0, 3);
  end

  // bench-side datapath: executes instr0 while the sequencer is in EXEC
  always @(posedge clk)
    if (dp_clr) for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
    else if (cs == 4'd1)
      case (instr0[31:24])
        8'h02: regs[instr0[18:16]] <= {16'h0, instr0[15:0]};
        8'h14: regs[instr0[18:16]] <= regs[instr0[10:8]] + regs[instr0[2:0]];
        8'h15: regs[instr0[18:16]] <= regs[instr0[10:8]] - regs[instr0[2:0]];
        8'hd2: regs[instr0[18:16]] <= regs[instr0[10:8]];
        default: ;
      endcase

  osecpu_seq_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_step_mode(step_mode), .i_step(step),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_data(idata),
    .i_ireg_d0(d0), .o_instr0(instr0), .o_current_state(cs), .o_pc(pc), .o_dr(dr),
    .o_dr_valid(drv), .o_halted(halted), .o_error(error)
  );

  osecpu_seq_ctrl #(.PC_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_start(start2), .i_step_mode(1'b0), .i_step(1'b0),
    .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_ack(req2), .i_imem_data(32'h0),
    .i_ireg_d0(32'h0), .o_instr0(instr2), .o_current_state(cs2), .o_pc(pc2), .o_dr(dr2),
    .o_dr_valid(drv2), .o_halted(halted2), .o_error(error2)
  );

  function automatic bit legal_op(input logic [7:0] op);
    return op inside {8'h00, 8'h02, 8'hd2, 8'h14, 8'h15, 8'hd3};
  endfunction

  function automatic int qdiff(input logic [31:0] a[$], input logic [31:0] b[$]);
    if (a.size() != b.size()) return 1;
    foreach (a[i]) if (a[i] !== b[i]) return 1;
    return 0;
  endfunction

  // instruction-level interpreter of the program starting at address 0
  task automatic model_run();
    logic [31:0] r [0:7];
    logic [31:0] w;
    logic [9:0] p;
    xw.delete(); xdr.delete();
    for (int i = 0; i < 8; i++) r[i] = 0;
    p = 0;
    xstate = 4'd2;
    for (int k = 0; k < 1024; k++) begin
      w = mem[p];
      p = p + 1;
      if (w[31:24] == 8'hff) begin xstate = 4'd4; break; end
      if (!legal_op(w[31:24])) begin xstate = 4'd5; break; end
      xw.push_back(w);
      case (w[31:24])
        8'h02: r[w[18:16]] = {16'h0, w[15:0]};
        8'h14: r[w[18:16]] = r[w[10:8]] + r[w[2:0]];
        8'h15: r[w[18:16]] = r[w[10:8]] - r[w[2:0]];
        8'hd2: r[w[18:16]] = r[w[10:8]];
        8'hd3: xdr.push_back(r[w[18:16]]);
        default: ;
      endcase
    end
    xpc = p;
  endtask

  task automatic clear_log();
    ex_w.delete(); ex_c.delete(); dr_w.delete(); dr_c.delete(); cp_c.delete(); runs.delete();
    run_len = 0; bad_addr = 0; bad_instr = 0; prev_acc = 0; prev_instr = instr0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cs == 4'd1) begin
      ex_w.push_back(instr0); ex_c.push_back(cyc);
      if (instr0[31:24] == 8'hd3) cp_c.push_back(cyc);
    end
    if (drv) begin dr_w.push_back(dr); dr_c.push_back(cyc); end
    if (instr0 !== prev_instr && !prev_acc) bad_instr++;
    prev_instr = instr0;
    if (req) begin
      if (run_len > 0 && addr !== run_addr) bad_addr++;
      run_addr = addr; run_len++;
    end else run_len = 0;
    prev_acc = req && ack;
    if (req && ack) begin runs.push_back(run_len); run_len = 0; end
  endtask

  task automatic run_prog(input int budget, output int c0);
    dp_clr = 1; tick(); dp_clr = 0;
    clear_log();
    c0 = cyc;
    start = 1; tick(); start = 0;
    for (int k = 0; k < budget && !(cs == 4'd4 || cs == 4'd5); k++) tick();
    checks++;
    if (!(cs == 4'd4 || cs == 4'd5)) begin errors++; $display("FAIL run_done: state=%0d want 4 or 5", cs); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (cs !== 4'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", cs); end
    checks++; if (pc !== 10'd0 || instr0 !== 32'h0 || dr !== 32'h0) begin errors++; $display("FAIL rst_regs: pc=%0h instr0=%0h dr=%0h want 0", pc, instr0, dr); end
    checks++; if ({req, drv, halted, error} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {req, drv, halted, error}); end
    reset = 0;
    step = 1; tick(); step = 0; tick();
    checks++; if (cs !== 4'd0 || req !== 1'b0) begin errors++; $display("FAIL idle_step: state=%0d req=%b want 0/0", cs, req); end
  endtask

  task automatic test_program();
    int c0, bad;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hff000000;
    mem[0] = 32'h02010005; mem[1] = 32'h14020101; mem[2] = 32'hd3020000; mem[3] = 32'hff000000;
    rand_mode = 0; delay = 0;
    model_run();
    run_prog(100, c0);
    checks++; if (ex_c.size() < 1 || ex_c[0] !== c0 + 2) begin errors++; $display("FAIL first_exec: got cycle %0d want %0d", ex_c.size() ? ex_c[0] - c0 : -1, 2); end
    bad = 0;
    for (int i = 1; i < ex_c.size(); i++) if (ex_c[i] - ex_c[i-1] != 2) bad++;
    checks++; if (bad != 0 || ex_c.size() != 3) begin errors++; $display("FAIL exec_spacing: bad=%0d execs=%0d want 0/3", bad, ex_c.size()); end
    checks++; if (qdiff(ex_w, xw) != 0) begin errors++; $display("FAIL exec_seq: got %0d instrs want %0d", ex_w.size(), xw.size()); end
    checks++; if (dr !== 32'h0000000A) begin errors++; $display("FAIL dr_value: got %0h want a", dr); end
    checks++; if (dr_c.size() != 1 || cp_c.size() != 1 || dr_c[0] !== cp_c[0] + 1) begin errors++; $display("FAIL dr_valid_pulse: pulses=%0d want 1 one cycle after CPDR", dr_c.size()); end
    checks++; if (halted !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL halted: got %b/%b want 1/0", halted, error); end
    checks++; if (pc !== 10'd4) begin errors++; $display("FAIL halt_pc: got %0d want 4", pc); end
  endtask

  task automatic test_delay();
    int c0, bad;
    mem[0] = 32'h02010007; mem[1] = 32'h15020101; mem[2] = 32'hd2030100; mem[3] = 32'hd3030000; mem[4] = 32'hff000000;
    rand_mode = 0; delay = 3;
    model_run();
    run_prog(200, c0);
    bad = 0;
    foreach (runs[i]) if (runs[i] != 4) bad++;
    checks++; if (runs.size() != 5 || bad != 0) begin errors++; $display("FAIL req_hold: fetches=%0d bad=%0d want 5/0", runs.size(), bad); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL addr_stable: got %0d changes want 0", bad_addr); end
    checks++; if (bad_instr != 0) begin errors++; $display("FAIL instr0_only_on_ack: got %0d changes want 0", bad_instr); end
    checks++; if (ex_c.size() < 1 || ex_c[0] !== c0 + 5) begin errors++; $display("FAIL delayed_first_exec: got %0d want %0d", ex_c.size() ? ex_c[0] - c0 : -1, 5); end
    checks++; if (qdiff(ex_w, xw) != 0 || qdiff(dr_w, xdr) != 0) begin errors++; $display("FAIL delay_seq: execs=%0d/%0d drs=%0d/%0d", ex_w.size(), xw.size(), dr_w.size(), xdr.size()); end
    delay = 0;
  endtask

  task automatic test_step();
    logic [9:0] p;
    mem[0] = 32'h02031234; mem[1] = 32'hd3030000; mem[2] = 32'h14040303; mem[3] = 32'hff000000;
    model_run();
    dp_clr = 1; tick(); dp_clr = 0;
    clear_log();
    step_mode = 1;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 20 && cs !== 4'd3; k++) tick();
      checks++; if (cs !== 4'd3 || ex_w.size() != i + 1) begin errors++; $display("FAIL step_pause%0d: state=%0d execs=%0d want 3/%0d", i, cs, ex_w.size(), i + 1); end
      p = pc;
      start = 1; repeat (4) tick(); start = 0;
      checks++; if (cs !== 4'd3 || ex_w.size() != i + 1 || pc !== p) begin errors++; $display("FAIL pause_start%0d: state=%0d execs=%0d pc=%0d want 3/%0d/%0d", i, cs, ex_w.size(), pc, i + 1, p); end
      step = 1; tick(); step = 0;
    end
    for (int k = 0; k < 20 && cs !== 4'd4; k++) tick();
    checks++; if (cs !== 4'd4 || qdiff(ex_w, xw) != 0) begin errors++; $display("FAIL step_end: state=%0d execs=%0d want 4/%0d", cs, ex_w.size(), xw.size()); end
    checks++; if (dr !== 32'h00001234) begin errors++; $display("FAIL step_dr: got %0h want 1234", dr); end
    step_mode = 0;
  endtask

  task automatic test_illegal();
    int c0;
    mem[0] = 32'h00000000; mem[1] = 32'h77123456; mem[2] = 32'hff000000;
    run_prog(100, c0);
    checks++; if (cs !== 4'd5 || error !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL illegal_err: state=%0d err=%b halt=%b want 5/1/0", cs, error, halted); end
    checks++; if (ex_w.size() != 1 || pc !== 10'd2) begin errors++; $display("FAIL illegal_noexec: execs=%0d pc=%0d want 1/2", ex_w.size(), pc); end
    start = 1; tick(); start = 0;
    checks++; if (error !== 1'b0 || req !== 1'b1 || addr !== 10'd0) begin errors++; $display("FAIL err_restart: err=%b req=%b addr=%0d want 0/1/0", error, req, addr); end
    for (int k = 0; k < 20 && cs !== 4'd5; k++) tick();
  endtask

  task automatic test_timeout();
    int n;
    ack_en = 0;
    clear_log();
    start = 1; tick(); start = 0;
    n = 0;
    for (int k = 0; k < 400 && cs !== 4'd5; k++) begin
      if (req) n++;
      tick();
    end
    checks++; if (n != TO) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
    checks++; if (cs !== 4'd5 || req !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL timeout_err: state=%0d req=%b err=%b want 5/0/1", cs, req, error); end
    ack_en = 1;
  endtask

  task automatic test_reset_mid();
    ack_en = 0;
    start = 1; tick(); start = 0; tick(); tick();
    checks++; if (req !== 1'b1 || instr0 === 32'h0) begin errors++; $display("FAIL pre_reset: req=%b instr0=%0h want 1/nonzero", req, instr0); end
    #2 reset = 1;
    #1;
    checks++; if (req !== 1'b0 || cs !== 4'd0) begin errors++; $display("FAIL async_req: req=%b state=%0d want 0/0", req, cs); end
    checks++; if (pc !== 10'd0 || instr0 !== 32'h0 || dr !== 32'h0 || {drv, halted, error} !== 3'b0) begin errors++; $display("FAIL async_regs: pc=%0h instr0=%0h dr=%0h flags=%b want zeros", pc, instr0, dr, {drv, halted, error}); end
    @(negedge clk); reset = 0; ack_en = 1;
  endtask

  task automatic test_wrap();
    int n;
    rst2 = 0;
    start2 = 1; tick(); start2 = 0;
    n = 0;
    for (int k = 0; k < 30 && n < 6; k++) begin
      if (req2) begin
        checks++; if (addr2 !== 2'(n % 4)) begin errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", n, addr2, n % 4); end
        n++;
      end
      tick();
    end
    checks++; if (n != 6 || pc2 !== 2'd2 || cs2 === 4'd4 || cs2 === 4'd5) begin errors++; $display("FAIL wrap_end: fetches=%0d pc=%0d state=%0d want 6/2/running", n, pc2, cs2); end
  endtask

  task automatic test_random();
    int c0, len, bad;
    logic [7:0] op;
    logic [7:0] ops [6];
    ops = '{8'h00, 8'h02, 8'hd2, 8'h14, 8'h15, 8'hd3};
    rand_mode = 1;
    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) mem[i] = {ops[$urandom_range(0, 5)], 24'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        do op = 8'($urandom); while (legal_op(op) || op == 8'hff);
        mem[$urandom_range(0, len - 1)] = {op, 24'($urandom)};
      end
      mem[len] = {8'hff, 24'($urandom)};
      model_run();
      run_prog(400, c0);
      bad = 0;
      for (int i = 0; i < cp_c.size() && i < dr_c.size(); i++) if (dr_c[i] != cp_c[i] + 1) bad++;
      checks++; if (qdiff(ex_w, xw) != 0) begin errors++; $display("FAIL rnd%0d_exec: got %0d instrs want %0d", it, ex_w.size(), xw.size()); end
      checks++; if (qdiff(dr_w, xdr) != 0 || bad != 0) begin errors++; $display("FAIL rnd%0d_dr: got %0d values want %0d (late %0d)", it, dr_w.size(), xdr.size(), bad); end
      checks++; if (cs !== xstate) begin errors++; $display("FAIL rnd%0d_state: got %0d want %0d", it, cs, xstate); end
      checks++; if (pc !== xpc) begin errors++; $display("FAIL rnd%0d_pc: got %0d want %0d", it, pc, xpc); end
      checks++; if (bad_instr != 0 || bad_addr != 0) begin errors++; $display("FAIL rnd%0d_stability: instr0 %0d addr %0d want 0/0", it, bad_instr, bad_addr); end
    end
    rand_mode = 0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_delay();
    test_step();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
